overrun_reporter: RTL and testbench

OVERRUN_REPORTER -- requirements
Module: overrun_reporter

---
 rtl/overrun_reporter_pkg.sv | 16 +
 rtl/overrun_reporter_rise_detect.sv | 28 ++
 rtl/overrun_reporter.sv | 118 +++++++++++
 tb/tb_overrun_reporter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/overrun_reporter_pkg.sv
// overrun_reporter_pkg
//   Shared definitions for the over-run reporter: the report FSM state type
//   and the default values of the reporter's parameters.
package overrun_reporter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REPORT = 2'd1,
      HOLD   = 2'd2
   } state_t;

   localparam int unsigned DEF_COUNTER_MSB    = 6;
   localparam int unsigned DEF_EVENT_MSB      = 7;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/overrun_reporter_rise_detect.sv
// rise_detect
//   Registers a level input once per clock and flags the cycle in which the
//   level is high while its registered copy is still low.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (clears the registered copy)
//   level  in   monitored level
//   pulse  out  level & ~registered level (combinational)
module rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic pulse
);

   logic level_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level;
      end
   end

   assign pulse = level & ~level_q;

endmodule

// File: rtl/overrun_reporter.sv
// overrun_reporter
//   Watches an upstream counter's over-run level. On an over-run rising edge
//   while idle it captures the count and offers it as a valid/ready report.
//   Edges seen while a report is pending or being held off are flagged as
//   missed. All edges are tallied in a saturating event counter.
//   Optional build macro OVERRUN_REPORTER_TIMEOUT_EN: abandons a report that
//   is not accepted within TIMEOUT_CYCLES cycles and sets o_DROPPED.
// Ports:
//   i_CLK       in   clock, rising edge
//   i_RST_N     in   asynchronous active-low reset
//   i_COUNT     in   upstream count value
//   i_OVER_RUN  in   upstream over-run level
//   i_READY     in   consumer accepts the report
//   o_VALID     out  report available (registered)
//   o_CAPTURED  out  count sampled at the accepted over-run edge
//   o_EVENTS    out  saturating tally of over-run rising edges
//   o_MISSED    out  sticky: an edge arrived outside IDLE
//   o_DROPPED   out  sticky: a report timed out (0 without the macro)
module overrun_reporter
   import overrun_reporter_pkg::*;
#(
   parameter int unsigned COUNTER_MSB    = DEF_COUNTER_MSB,
   parameter int unsigned EVENT_MSB      = DEF_EVENT_MSB,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                 i_CLK,
   input  logic                 i_RST_N,
   input  logic [COUNTER_MSB:0] i_COUNT,
   input  logic                 i_OVER_RUN,
   input  logic                 i_READY,
   output logic                 o_VALID,
   output logic [COUNTER_MSB:0] o_CAPTURED,
   output logic [EVENT_MSB:0]   o_EVENTS,
   output logic                 o_MISSED,
   output logic                 o_DROPPED
);

   state_t state;
   logic   rise;

   rise_detect u_rise_detect (
      .clk   (i_CLK),
      .rst_n (i_RST_N),
      .level (i_OVER_RUN),
      .pulse (rise)
   );

`ifdef OVERRUN_REPORTER_TIMEOUT_EN
   localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TIMER_W-1:0] timer;
`else
   localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
   assign o_DROPPED = 1'b0;
`endif

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         state      <= IDLE;
         o_VALID    <= 1'b0;
         o_CAPTURED <= '0;
         o_EVENTS   <= '0;
         o_MISSED   <= 1'b0;
`ifdef OVERRUN_REPORTER_TIMEOUT_EN
         o_DROPPED  <= 1'b0;
         timer      <= '0;
`endif
      end else begin
         if (rise && (o_EVENTS != '1)) begin
            o_EVENTS <= o_EVENTS + 1'b1;
         end
         case (state)
            IDLE: begin
               if (rise) begin
                  state      <= REPORT;
                  o_VALID    <= 1'b1;
                  o_CAPTURED <= i_COUNT;
`ifdef OVERRUN_REPORTER_TIMEOUT_EN
                  timer      <= '0;
`endif
               end
            end
            REPORT: begin
               if (rise) begin
                  o_MISSED <= 1'b1;
               end
               // o_VALID is 1 throughout REPORT, so i_READY alone completes
               // the transfer; a simultaneous edge only counts as missed.
               if (i_READY) begin
                  state   <= HOLD;
                  o_VALID <= 1'b0;
               end
`ifdef OVERRUN_REPORTER_TIMEOUT_EN
               else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                  state     <= HOLD;
                  o_VALID   <= 1'b0;
                  o_DROPPED <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
`endif
            end
            HOLD: begin
               if (rise) begin
                  o_MISSED <= 1'b1;
               end
               if (!i_OVER_RUN) begin
                  state <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               o_VALID <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_overrun_reporter.sv
module tb_overrun_reporter;

   logic       clk;
   logic       rst_n;
   logic [6:0] count;
   logic       over_run;
   logic       ready;

   logic       valid;
   logic [6:0] captured;
   logic [7:0] events;
   logic       missed;
   logic       dropped;

   logic       valid2;
   logic [6:0] captured2;
   logic [1:0] events2;
   logic       missed2;
   logic       dropped2;

   int checks;
   int failures;

   overrun_reporter #(
      .COUNTER_MSB    (6),
      .EVENT_MSB      (7),
      .TIMEOUT_CYCLES (255)
   ) dut (
      .i_CLK      (clk),
      .i_RST_N    (rst_n),
      .i_COUNT    (count),
      .i_OVER_RUN (over_run),
      .i_READY    (ready),
      .o_VALID    (valid),
      .o_CAPTURED (captured),
      .o_EVENTS   (events),
      .o_MISSED   (missed),
      .o_DROPPED  (dropped)
   );

   overrun_reporter #(
      .COUNTER_MSB    (6),
      .EVENT_MSB      (1),
      .TIMEOUT_CYCLES (4)
   ) dut_small (
      .i_CLK      (clk),
      .i_RST_N    (rst_n),
      .i_COUNT    (count),
      .i_OVER_RUN (over_run),
      .i_READY    (ready),
      .o_VALID    (valid2),
      .o_CAPTURED (captured2),
      .o_EVENTS   (events2),
      .o_MISSED   (missed2),
      .o_DROPPED  (dropped2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n    = 1'b0;
      over_run = 1'b0;
      ready    = 1'b0;
      count    = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      rst_n    = 1'b0;
      over_run = 1'b1;
      ready    = 1'b0;
      count    = 7'd5;
      tick();
      tick();
      checks++;
      if ({valid, captured, events, missed, dropped} !== 18'd0) begin
         failures++;
         $display("FAIL reset_outputs: got v=%0b c=%0d e=%0d m=%0b d=%0b want all 0",
                  valid, captured, events, missed, dropped);
      end
      checks++;
      if ({valid2, captured2, events2, missed2, dropped2} !== 12'd0) begin
         failures++;
         $display("FAIL reset_outputs_small: got v=%0b c=%0d e=%0d want all 0",
                  valid2, captured2, events2);
      end
      over_run = 1'b0;
      rst_n    = 1'b1;
      tick();
   endtask

   task automatic test_ramp_capture;
      do_reset();
      ready = 1'b1;
      for (int i = 0; i < 127; i++) begin
         count = 7'(i);
         tick();
      end
      checks++;
      if (valid !== 1'b0) begin
         failures++;
         $display("FAIL ramp_no_early_valid: got %0b want 0", valid);
      end
      count    = 7'd127;
      over_run = 1'b1;
      tick();
      checks++;
      if (valid !== 1'b1) begin
         failures++;
         $display("FAIL ramp_valid: got %0b want 1", valid);
      end
      checks++;
      if (captured !== 7'd127) begin
         failures++;
         $display("FAIL ramp_captured: got %0d want 127", captured);
      end
      checks++;
      if (events !== 8'd1) begin
         failures++;
         $display("FAIL ramp_events: got %0d want 1", events);
      end
      count = 7'd0;
      tick();
      checks++;
      if (valid !== 1'b0) begin
         failures++;
         $display("FAIL ramp_valid_one_cycle: got %0b want 0", valid);
      end
      checks++;
      if (missed !== 1'b0 || events !== 8'd1) begin
         failures++;
         $display("FAIL ramp_after: got missed=%0b events=%0d want 0/1", missed, events);
      end
      over_run = 1'b0;
      tick();
   endtask

   task automatic test_stall;
      int vcnt;
      int unstable;
      do_reset();
      vcnt     = 0;
      unstable = 0;
      count    = 7'd55;
      over_run = 1'b1;
      tick();
      repeat (10) begin
         if (valid === 1'b1) vcnt++;
         if (captured !== 7'd55) unstable++;
         count = count + 7'd1;
         tick();
      end
      ready = 1'b1;
      if (valid === 1'b1) vcnt++;
      if (captured !== 7'd55) unstable++;
      tick();
      repeat (3) begin
         if (valid === 1'b1) vcnt++;
         tick();
      end
      checks++;
      if (vcnt !== 11) begin
         failures++;
         $display("FAIL stall_valid_cycles: got %0d want 11", vcnt);
      end
      checks++;
      if (unstable !== 0 || captured !== 7'd55) begin
         failures++;
         $display("FAIL stall_captured_stable: got unstable=%0d captured=%0d want 0/55",
                  unstable, captured);
      end
      checks++;
      if (events !== 8'd1) begin
         failures++;
         $display("FAIL stall_events: got %0d want 1", events);
      end
      over_run = 1'b0;
      ready    = 1'b0;
      tick();
   endtask

   task automatic test_missed;
      do_reset();
      count    = 7'd10;
      over_run = 1'b1;
      tick();
      over_run = 1'b0;
      tick();
      count    = 7'd20;
      over_run = 1'b1;
      tick();
      checks++;
      if (missed !== 1'b1) begin
         failures++;
         $display("FAIL missed_flag: got %0b want 1", missed);
      end
      checks++;
      if (events !== 8'd2) begin
         failures++;
         $display("FAIL missed_events: got %0d want 2", events);
      end
      checks++;
      if (captured !== 7'd10 || valid !== 1'b1) begin
         failures++;
         $display("FAIL missed_report_kept: got captured=%0d valid=%0b want 10/1",
                  captured, valid);
      end
      ready = 1'b1;
      tick();
      over_run = 1'b0;
      ready    = 1'b0;
      tick();
      tick();
      checks++;
      if (missed !== 1'b1) begin
         failures++;
         $display("FAIL missed_sticky: got %0b want 1", missed);
      end
   endtask

   task automatic test_back_to_back;
      do_reset();
      count    = 7'd30;
      over_run = 1'b1;
      tick();
      over_run = 1'b0;
      tick();
      // transfer and a new rising edge on the same clock
      ready    = 1'b1;
      count    = 7'd99;
      over_run = 1'b1;
      tick();
      checks++;
      if (valid !== 1'b0 || missed !== 1'b1 || events !== 8'd2 || captured !== 7'd30) begin
         failures++;
         $display("FAIL collision: got v=%0b m=%0b e=%0d c=%0d want 0/1/2/30",
                  valid, missed, events, captured);
      end
      tick();
      checks++;
      if (valid !== 1'b0) begin
         failures++;
         $display("FAIL hold_while_high: got %0b want 0", valid);
      end
      over_run = 1'b0;
      tick();
      count    = 7'd77;
      over_run = 1'b1;
      tick();
      checks++;
      if (valid !== 1'b1 || captured !== 7'd77 || events !== 8'd3) begin
         failures++;
         $display("FAIL recapture: got v=%0b c=%0d e=%0d want 1/77/3",
                  valid, captured, events);
      end
      over_run = 1'b0;
      tick();
      tick();
      ready = 1'b0;
   endtask

   task automatic test_saturate;
      do_reset();
      ready = 1'b1;
      for (int p = 1; p <= 5; p++) begin
         count    = 7'(p);
         over_run = 1'b1;
         tick();
         tick();
         over_run = 1'b0;
         tick();
         tick();
         if (p == 3) begin
            checks++;
            if (events2 !== 2'd3) begin
               failures++;
               $display("FAIL saturate_reach: got %0d want 3", events2);
            end
         end
      end
      checks++;
      if (events2 !== 2'd3) begin
         failures++;
         $display("FAIL saturate_hold: got %0d want 3", events2);
      end
      checks++;
      if (events !== 8'd5 || missed2 !== 1'b0) begin
         failures++;
         $display("FAIL saturate_wide: got events=%0d missed2=%0b want 5/0", events, missed2);
      end
      ready = 1'b0;
   endtask

   task automatic test_reset_mid_report;
      do_reset();
      count    = 7'd33;
      over_run = 1'b1;
      tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({valid, captured, events, missed, dropped} !== 18'd0) begin
         failures++;
         $display("FAIL reset_async: got v=%0b c=%0d e=%0d m=%0b want all 0",
                  valid, captured, events, missed);
      end
      count = 7'd44;
      tick();
      checks++;
      if (valid !== 1'b0 || events !== 8'd0) begin
         failures++;
         $display("FAIL reset_held: got v=%0b e=%0d want 0/0", valid, events);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (valid !== 1'b1 || captured !== 7'd44 || events !== 8'd1 || missed !== 1'b0) begin
         failures++;
         $display("FAIL reset_recapture: got v=%0b c=%0d e=%0d m=%0b want 1/44/1/0",
                  valid, captured, events, missed);
      end
      over_run = 1'b0;
      ready    = 1'b1;
      tick();
      tick();
      ready = 1'b0;
   endtask

   task automatic test_timeout;
      int vcnt;
      do_reset();
      vcnt     = 0;
      count    = 7'd9;
      over_run = 1'b1;
      tick();
      over_run = 1'b0;
      repeat (8) begin
         if (valid2 === 1'b1) vcnt++;
         tick();
      end
`ifdef OVERRUN_REPORTER_TIMEOUT_EN
      checks++;
      if (vcnt !== 4 || valid2 !== 1'b0) begin
         failures++;
         $display("FAIL timeout_valid: got cycles=%0d valid=%0b want 4/0", vcnt, valid2);
      end
      checks++;
      if (dropped2 !== 1'b1) begin
         failures++;
         $display("FAIL timeout_dropped: got %0b want 1", dropped2);
      end
`else
      checks++;
      if (vcnt !== 8 || valid2 !== 1'b1) begin
         failures++;
         $display("FAIL no_timeout_valid: got cycles=%0d valid=%0b want 8/1", vcnt, valid2);
      end
      checks++;
      if (dropped2 !== 1'b0 || dropped !== 1'b0) begin
         failures++;
         $display("FAIL no_timeout_dropped: got %0b/%0b want 0/0", dropped2, dropped);
      end
`endif
      checks++;
      if (captured2 !== 7'd9) begin
         failures++;
         $display("FAIL timeout_captured: got %0d want 9", captured2);
      end
      ready = 1'b1;
      tick();
      tick();
      ready = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      over_run = 1'b0;
      ready    = 1'b0;
      count    = '0;
      test_reset();
      test_ramp_capture();
      test_stall();
      test_missed();
      test_back_to_back();
      test_saturate();
      test_reset_mid_report();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
